// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE and per-opcode execute, memory and writeback.
// Optional MEM_WAIT_EN stalls FETCH/MEMRD/MEMWR until mem_ready is high.
module multicycle_control #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned STATE_W = 4
) (
    input  logic               clock,
    input  logic               Reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   instr_count,
    output logic [STATE_W-1:0] state
);

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpAddi = 6'b001000;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11
    } state_e;

    state_e           state_q, state_d;
    logic [5:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] count_q;
    logic             mem_ok;
    logic             legal;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    always_comb begin
        legal = 1'b1;
        case (opcode)
            OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ok) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpR:        state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    default:    state_d = StFetch;
                endcase
            end
            // Only lw/sw reach MEMADR, so the latched opcode picks between them.
            StMemAdr: state_d = (op_q == OpSw) ? StMemWr : StMemRd;
            StMemRd:  if (mem_ok) state_d = StMemWb;
            StMemWr:  if (mem_ok) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= StFetch;
            op_q      <= 6'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_q == StDecode) && !legal;
            if (state_q == StDecode) begin
                op_q <= opcode;
            end
            if (instr_done && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Moore decode; everything is held low while Reset is asserted.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        if (!Reset) begin
            case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    ir_write  = mem_ok;
                    pc_write  = mem_ok;
                    alu_src_b = 2'b01;
                end
                StDecode: alu_src_b = 2'b11;
                StMemAdr, StAddiEx: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                StMemWr: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ok;
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                StExec: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                StAluWb: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                StAddiWb: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                StBranch: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                StJump: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign illegal_op  = illegal_q & ~Reset;
    assign instr_count = count_q;
    assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control; a second CNT_W=4 instance checks saturation.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        int         st;
        int         cnt;
        logic       ill;
    } vec_t;

    logic        clock = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  opcode = 6'b0;
    logic        mem_ready = 1'b1;

    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [15:0] instr_count;
    logic [3:0]  state;

    logic        s_pcw, s_pcwc, s_iord, s_mr, s_mw, s_irw, s_m2r, s_rd, s_rw, s_asa;
    logic        s_done, s_ill;
    logic [1:0]  s_asb, s_aop, s_pcs;
    logic [3:0]  s_count;
    logic [3:0]  s_state;

    ctrl_t act;
    assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
                  illegal_op};

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    multicycle_control #(.CNT_W(16), .STATE_W(4)) u_dut (
        .clock(clock), .Reset(Reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .instr_count(instr_count), .state(state)
    );

    multicycle_control #(.CNT_W(4), .STATE_W(4)) u_sat (
        .clock(clock), .Reset(Reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(s_pcw), .pc_write_cond(s_pcwc), .i_or_d(s_iord),
        .mem_read(s_mr), .mem_write(s_mw), .ir_write(s_irw),
        .mem_to_reg(s_m2r), .reg_dst(s_rd), .reg_write(s_rw),
        .alu_src_a(s_asa), .alu_src_b(s_asb), .alu_op(s_aop),
        .pc_source(s_pcs), .instr_done(s_done), .illegal_op(s_ill),
        .instr_count(s_count), .state(s_state)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expect_v);
        checks++;
        if (actual !== expect_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expect_v, $time);
        end
    endtask

    // Hand-written control word for each state.
    function automatic ctrl_t exp_ctrl(input int st, input logic ill);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.pc_write = 1; c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; end
            1:  c.alu_src_b = 2'b11;
            2, 10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  begin c.mem_read = 1; c.i_or_d = 1; end
            4:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
            5:  begin c.mem_write = 1; c.i_or_d = 1; c.instr_done = 1; end
            6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7:  begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
            8:  begin
                c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                c.pc_source = 2'b01; c.instr_done = 1;
            end
            9:  begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
            11: begin c.reg_write = 1; c.instr_done = 1; end
            default: c = '0;
        endcase
        c.illegal_op = ill;
        return c;
    endfunction

    task automatic add(input logic [5:0] op, input int st, input int cnt, input logic ill);
        vec_t v;
        v.op = op; v.st = st; v.cnt = cnt; v.ill = ill;
        vecs.push_back(v);
    endtask

    initial begin
        // lw
        add(6'b100011, 0, 0, 0); add(6'b100011, 1, 0, 0); add(6'b100011, 2, 0, 0);
        add(6'b100011, 3, 0, 0); add(6'b100011, 4, 0, 0);
        // R, addi, sw, beq, j back-to-back
        add(6'b000000, 0, 1, 0); add(6'b000000, 1, 1, 0);
        add(6'b000000, 6, 1, 0); add(6'b000000, 7, 1, 0);
        add(6'b001000, 0, 2, 0); add(6'b001000, 1, 2, 0);
        add(6'b001000, 10, 2, 0); add(6'b001000, 11, 2, 0);
        add(6'b101011, 0, 3, 0); add(6'b101011, 1, 3, 0);
        add(6'b101011, 2, 3, 0); add(6'b101011, 5, 3, 0);
        add(6'b000100, 0, 4, 0); add(6'b000100, 1, 4, 0); add(6'b000100, 8, 4, 0);
        add(6'b000010, 0, 5, 0); add(6'b000010, 1, 5, 0); add(6'b000010, 9, 5, 0);
        // illegal opcode: back to FETCH with a one-cycle pulse, count unchanged
        add(6'b111111, 0, 6, 0); add(6'b111111, 1, 6, 0);
        add(6'b111111, 0, 6, 1); add(6'b111111, 1, 6, 0);

        @(posedge clock);
        @(negedge clock);
        #1;
        check("reset_outputs_zero", 32'(act), 32'(ctrl_t'('0)));
        check("reset_state", 32'(state), 0);
        @(posedge clock);
        @(negedge clock);
        Reset = 1'b0;
        #1;
        check("post_reset_state", 32'(state), 0);
        check("post_reset_count", 32'(instr_count), 0);

        foreach (vecs[i]) begin
            opcode = vecs[i].op;
            #1;
            check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("v%0d_ctrl", i), 32'(act), 32'(exp_ctrl(vecs[i].st, vecs[i].ill)));
            check($sformatf("v%0d_count", i), 32'(instr_count), 32'(vecs[i].cnt));
            @(negedge clock);
        end

        // Last vector was DECODE of an illegal op; the next cycle is FETCH. Start a lw there.
        opcode = 6'b100011;
        repeat (3) @(negedge clock);
        #1;
        check("abort_in_memrd", 32'(state), 3);
        #2;
        Reset = 1'b1;
        #1;
        check("abort_state", 32'(state), 0);
        check("abort_outputs_zero", 32'(act), 32'(ctrl_t'('0)));
        check("abort_count", 32'(instr_count), 0);
        @(posedge clock);
        #1;
        check("abort_hold_reg_write", 32'(reg_write), 0);
        @(negedge clock);
        Reset = 1'b0;
        #1;
        check("abort_release_state", 32'(state), 0);
        check("abort_release_ctrl", 32'(act), 32'(exp_ctrl(0, 1'b0)));

        // 17 R-type instructions: the CNT_W=4 instance must stick at 4'hF.
        opcode = 6'b000000;
        repeat (64) @(negedge clock);
        #1;
        check("sat_at_16", 32'(s_count), 32'hF);
        check("wide_at_16", 32'(instr_count), 16);
        repeat (4) @(negedge clock);
        #1;
        check("sat_no_wrap", 32'(s_count), 32'hF);
        check("wide_at_17", 32'(instr_count), 17);
        check("sat_state_fetch", 32'(state), 0);

`ifdef MEM_WAIT_EN
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("wait%0d_state", k), 32'(state), 0);
            check($sformatf("wait%0d_pc_write", k), 32'(pc_write), 0);
            check($sformatf("wait%0d_ir_write", k), 32'(ir_write), 0);
            check($sformatf("wait%0d_mem_read", k), 32'(mem_read), 1);
            @(negedge clock);
        end
        mem_ready = 1'b1;
        #1;
        check("wait_release_pc_write", 32'(pc_write), 1);
        @(negedge clock);
        #1;
        check("wait_release_state", 32'(state), 1);
`else
        mem_ready = 1'b0;
        #1;
        check("ready_ignored_pc_write", 32'(pc_write), 1);
        @(negedge clock);
        #1;
        check("ready_ignored_state", 32'(state), 1);
        mem_ready = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
